sdffe_bank_arbiter: RTL and testbench

Shared-write-port controller for a bank of enable-only flip-flop registers (DFFE-class cells). It sequences a power-up/clear sweep that loads each register with its 0/1 clear value, then arbitrates round-robin among NREQ requesters for the single write port. It sits between the register-file consumers and the mapped flop bank, so the bank needs no per-register reset logic.

---
 rtl/sdffe_bank_arbiter.sv | 136 +++++++++++++
 tb/tb_sdffe_bank_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sdffe_bank_arbiter.sv
// Write-port controller for an enable-only register bank: a clear sweep after reset
// or clr_all, then round-robin arbitration of one write per cycle among NREQ requesters.
module sdffe_bank_arbiter #(
  parameter int              NREQ     = 4,
  parameter int              NREG     = 8,
  parameter int              WIDTH    = 8,
  parameter logic [NREG-1:0] CLR_MASK = 8'hAA,
  localparam int             AW       = $clog2(NREG),
  localparam int             IDW      = $clog2(NREQ)
) (
  input  logic                    C,
  input  logic                    R,
  input  logic                    clr_all,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_clr,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREG*WIDTH-1:0]   Q,
  output logic                    busy,
  output logic                    grant_valid,
  output logic [IDW-1:0]          grant_id,
  output logic                    err
);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q;
  logic [IDW-1:0]   rr_q;
  logic [WIDTH-1:0] bank [NREG];

  logic             gnt_any;
  logic [IDW-1:0]   gnt_k;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   next_rr;
  logic [NREQ-1:0]  ready;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic             sel_clr;
  logic             sel_oob;
  logic             sweep_wr;
  logic             last_idx;

  logic             gnt_vld_p1;
  logic [IDW-1:0]   gnt_id_p1;
  logic             err_p1;

  function automatic logic [WIDTH-1:0] clear_word(input logic [AW-1:0] a);
    return {WIDTH{CLR_MASK[a]}};
  endfunction

  // Round-robin search starting at rr; blocked during sweep, reset and clr_all.
  always_comb begin
    gnt_any = 1'b0;
    gnt_k   = '0;
    cand    = '0;
    ready   = '0;
    if (state_q == RUN && !R && !clr_all) begin
      for (int i = 0; i < NREQ; i++) begin
        cand = IDW'((int'(rr_q) + i) % NREQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_k   = cand;
        end
      end
    end
    if (gnt_any) ready[gnt_k] = 1'b1;
  end

  always_comb begin
    sel_addr = req_addr[int'(gnt_k)*AW +: AW];
    sel_data = req_data[int'(gnt_k)*WIDTH +: WIDTH];
    sel_clr  = req_clr[gnt_k];
    sel_oob  = (int'(sel_addr) >= NREG);
    next_rr  = IDW'((int'(gnt_k) + 1) % NREQ);
  end

  always_comb begin
    state_d  = state_q;
    sweep_wr = 1'b0;
    last_idx = (idx_q == AW'(NREG - 1));
    if (R) begin
      state_d = SWEEP;
    end else begin
      case (state_q)
        SWEEP: begin
          sweep_wr = 1'b1;
          if (last_idx) state_d = RUN;
        end
        RUN: if (clr_all) state_d = SWEEP;
        default: state_d = SWEEP;
      endcase
    end
  end

  // Stage p1: control state and grant report, aligned with the bank update.
  always_ff @(posedge C) begin
    if (R) begin
      state_q    <= SWEEP;
      idx_q      <= '0;
      rr_q       <= '0;
      gnt_vld_p1 <= 1'b0;
      gnt_id_p1  <= '0;
      err_p1     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= (sweep_wr && !last_idx) ? idx_q + AW'(1) : '0;
      gnt_vld_p1 <= gnt_any;
      err_p1     <= gnt_any && sel_oob;
      if (gnt_any) begin
        gnt_id_p1 <= gnt_k;
        rr_q      <= next_rr;
      end
    end
  end

  // Bank cells carry no reset; they are only ever loaded through this write port.
  always_ff @(posedge C) begin
    if (sweep_wr)
      bank[idx_q] <= clear_word(idx_q);
    else if (gnt_any && !sel_oob)
      bank[sel_addr] <= sel_clr ? clear_word(sel_addr) : sel_data;
  end

  for (genvar g = 0; g < NREG; g++) begin : g_q
    assign Q[g*WIDTH +: WIDTH] = bank[g];
  end

  assign req_ready   = ready;
  assign busy        = (state_q == SWEEP);
  assign grant_valid = gnt_vld_p1;
  assign grant_id    = gnt_id_p1;
  assign err         = err_p1;

endmodule

// File: tb/tb_sdffe_bank_arbiter.sv
// Randomized and directed bench for sdffe_bank_arbiter with a queue-based scoreboard
// fed by a spec-level model of the bank, pointer and sweep.
module tb_sdffe_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NREG  = 6;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int IDW   = 2;
  localparam logic [NREG-1:0] MASK = 6'b101010;

  logic                  clk = 1'b0;
  logic                  R, clr_all;
  logic [NREQ-1:0]       req_valid, req_clr, req_ready;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREG*WIDTH-1:0] Q;
  logic                  busy, grant_valid, err;
  logic [IDW-1:0]        grant_id;

  typedef struct {
    int                    due;
    int                    id;
    bit                    err;
    logic [NREG*WIDTH-1:0] q;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  bit               mon_gv;
  logic [WIDTH-1:0] m_bank [NREG];
  int               m_rr    = 0;
  int               m_sweep = NREG;
  logic [NREQ-1:0]  exp_ready = '0;
  int               nchk = 0, npass = 0, cyc = 0;
  bit               chk_en = 0;

  sdffe_bank_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH), .CLR_MASK(MASK)
  ) dut (
    .C(clk), .R(R), .clr_all(clr_all),
    .req_valid(req_valid), .req_clr(req_clr), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .Q(Q), .busy(busy),
    .grant_valid(grant_valid), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [NREG*WIDTH-1:0] snap();
    logic [NREG*WIDTH-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*WIDTH +: WIDTH] = m_bank[i];
    return v;
  endfunction

  // One clock: predict this cycle's grant from the current inputs, check the
  // combinational outputs, advance the model, queue the expected write report.
  task automatic step();
    int   found;
    int   a;
    exp_t e;
    #1;
    exp_ready = '0;
    found     = -1;
    if (!R && m_sweep == 0 && !clr_all)
      for (int i = 0; i < NREQ; i++)
        if (found < 0 && req_valid[(m_rr + i) % NREQ]) found = (m_rr + i) % NREQ;
    if (found >= 0) exp_ready[found] = 1'b1;
    if (chk_en) begin
      check("busy", busy, m_sweep > 0);
      check("req_ready", req_ready, exp_ready);
    end
    if (R) begin
      m_sweep = NREG;
      m_rr    = 0;
    end else if (m_sweep > 0) begin
      a         = NREG - m_sweep;
      m_bank[a] = {WIDTH{MASK[a]}};
      m_sweep--;
    end else if (clr_all) begin
      m_sweep = NREG;
    end else if (found >= 0) begin
      a = int'(req_addr[found*AW +: AW]);
      if (a < NREG)
        m_bank[a] = req_clr[found] ? {WIDTH{MASK[a]}} : req_data[found*WIDTH +: WIDTH];
      m_rr  = (found + 1) % NREQ;
      e.due = cyc + 1;
      e.id  = found;
      e.err = (a >= NREG);
      e.q   = snap();
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit clr, input int addr, input int data);
    req_valid[k]              = 1'b1;
    req_clr[k]                = clr;
    req_addr[k*AW +: AW]      = AW'(addr);
    req_data[k*WIDTH +: WIDTH] = WIDTH'(data);
  endtask

  task automatic drop_granted();
    req_valid = req_valid & ~exp_ready;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon_gv = (sb.size() > 0) && (sb[0].due == cyc);
      check("grant_valid", grant_valid, mon_gv);
      if (mon_gv) begin
        mon_e = sb.pop_front();
        check("grant_id", grant_id, mon_e.id);
        check("err", err, mon_e.err);
        check("bank_q", Q, mon_e.q);
      end
    end
  end

  initial begin
    for (int i = 0; i < NREG; i++) m_bank[i] = '0;
    R = 1'b1; clr_all = 1'b0;
    req_valid = '0; req_clr = '0; req_addr = '0; req_data = '0;
    step();
    chk_en = 1;
    step();
    R = 1'b0;
    repeat (NREG + 2) step();
    check("sweep_q", Q, 48'hFF00FF00FF00);

    // all requesters valid, requester k writes k with 0x10+k
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, k, 16 + k);
    repeat (8) step();
    req_valid = '0;
    step();
    check("rr_regs", Q[31:0], 32'h13121110);

    set_req(2, 1'b0, 1, 8'h5A);
    step(); drop_granted(); step();
    check("reg1_data", Q[15:8], 8'h5A);
    set_req(2, 1'b1, 1, 8'h00);
    step(); drop_granted(); step();
    check("reg1_clr", Q[15:8], 8'hFF);

    set_req(0, 1'b0, 7, 8'h33);
    step(); drop_granted(); step();
    check("oob_q", Q, snap());
    set_req(0, 1'b0, 4, 8'h44);
    set_req(1, 1'b0, 5, 8'h55);
    repeat (3) begin step(); drop_granted(); end

    req_valid = '0;
    set_req(1, 1'b0, 2, 8'hA1);
    set_req(3, 1'b0, 3, 8'hA3);
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
    repeat (NREG) step();
    repeat (3) begin step(); drop_granted(); end

    req_valid = '0;
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
    repeat (4) step();
    R = 1'b1;
    step();
    R = 1'b0;
    repeat (NREG + 2) step();

    repeat (600) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && !exp_ready[k]) begin
          if ($urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
        end else begin
          req_valid[k]               = ($urandom_range(0, 2) != 0);
          req_clr[k]                 = ($urandom_range(0, 3) == 0);
          req_addr[k*AW +: AW]       = AW'($urandom_range(0, 7));
          req_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      clr_all = ($urandom_range(0, 49) == 0);
      R       = ($urandom_range(0, 199) == 0);
      step();
    end

    R = 1'b0; clr_all = 1'b0; req_valid = '0;
    repeat (NREG + 3) step();
    check("sb_drained", sb.size(), 0);
    check("final_q", Q, snap());
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
